mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port. Requests are accepted on two request/ready handshakes. Each transaction is sequenced onto the memory bus, which may have variable latency. Data is returned with a one-cycle ready pulse, and a watchdog aborts stuck memory accesses.

---
 rtl/nano_rv32i_pkg.sv | 19 +
 rtl/mem_arb_sel.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_rv32i_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package nano_rv32i_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select between fetch and load/store requesters.
// MEM_ARB_RR_EN: when defined, simultaneous requests alternate using a
// last-grant pointer; otherwise the data port always wins and no pointer
// register exists.
module mem_arb_sel
    import nano_rv32i_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   grant_i,
`endif
    input  logic   i_req_i,
    input  logic   d_req_i,
    output logic   req_o,
    output owner_e win_o
);

    assign req_o = i_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
    owner_e last_q;
    owner_e last_d;

    // Winner: on a conflict, the port that did not win last time.
    always_comb begin
        win_o = OWN_I;
        if (i_req_i && d_req_i) begin
            win_o = (last_q == OWN_D) ? OWN_I : OWN_D;
        end else if (d_req_i) begin
            win_o = OWN_D;
        end
    end

    // Pointer follows every grant, not just contended ones.
    always_comb begin
        last_d = last_q;
        if (grant_i) begin
            last_d = win_o;
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= OWN_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Winner: fixed data-over-fetch priority.
    always_comb begin
        win_o = OWN_I;
        if (d_req_i) begin
            win_o = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports.
// Each access runs IDLE -> BUSY -> RESP; a watchdog ends BUSY after
// TIMEOUT_CYCLES without m_ready_i (0 disables it).
// MEM_ARB_RR_EN selects round-robin instead of fixed data priority.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no access in flight; pick a winner when any request is up
// ST_BUSY | strobes on the memory bus, waiting for m_ready_i or timeout
// ST_RESP | one-cycle ready pulse to the owner, err_o valid alongside
module mem_port_arbiter
    import nano_rv32i_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_rd_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_data_o,
    output logic              i_ready_o,
    input  logic              d_rd_i,
    input  logic              d_wr_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_data_i,
    output logic [DATA_W-1:0] d_data_o,
    output logic              d_ready_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_rd_o,
    output logic              m_wr_o,
    input  logic [DATA_W-1:0] m_data_i,
    input  logic              m_ready_i,
    output logic              err_o,
    output logic              busy_o
);

    // The counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires
    // in the BUSY cycle where it holds that value.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    state_e            state_q,  state_d;
    owner_e            owner_q,  owner_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_rd_q,   m_rd_d;
    logic              m_wr_q,   m_wr_d;
    logic [DATA_W-1:0] i_data_q, i_data_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              err_q,    err_d;

    logic   req_any;
    owner_e win;
    logic   timeout_hit;

`ifdef MEM_ARB_RR_EN
    logic grant;
    assign grant = (state_q == ST_IDLE) && req_any;
`endif

    mem_arb_sel u_sel (
`ifdef MEM_ARB_RR_EN
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .grant_i (grant),
`endif
        .i_req_i (i_rd_i),
        .d_req_i (d_rd_i | d_wr_i),
        .req_o   (req_any),
        .win_o   (win)
    );

    assign timeout_hit = WD_EN && (cnt_q == TO_LAST);

    // Next-state logic for the access sequencer and all output registers.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        m_addr_d = m_addr_q;
        m_data_d = m_data_q;
        m_rd_d   = m_rd_q;
        m_wr_d   = m_wr_q;
        i_data_d = i_data_q;
        d_data_d = d_data_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    owner_d = win;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                    if (win == OWN_D) begin
                        m_addr_d = d_addr_i;
                        m_data_d = d_data_i;
                        // A simultaneous read+write request is a write.
                        m_wr_d   = d_wr_i;
                        m_rd_d   = ~d_wr_i;
                    end else begin
                        m_addr_d = i_addr_i;
                        m_data_d = '0;
                        m_wr_d   = 1'b0;
                        m_rd_d   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // m_ready_i takes precedence over a coincident timeout.
                if (m_ready_i) begin
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    state_d = ST_RESP;
                    if (m_rd_q) begin
                        if (owner_q == OWN_D) begin
                            d_data_d = m_data_i;
                        end else begin
                            i_data_d = m_data_i;
                        end
                    end
                end else if (timeout_hit) begin
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                    if (owner_q == OWN_D) begin
                        d_data_d = '0;
                    end else begin
                        i_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_I;
            cnt_q    <= '0;
            m_addr_q <= '0;
            m_data_q <= '0;
            m_rd_q   <= 1'b0;
            m_wr_q   <= 1'b0;
            i_data_q <= '0;
            d_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            m_addr_q <= m_addr_d;
            m_data_q <= m_data_d;
            m_rd_q   <= m_rd_d;
            m_wr_q   <= m_wr_d;
            i_data_q <= i_data_d;
            d_data_q <= d_data_d;
            err_q    <= err_d;
        end
    end

    assign m_addr_o  = m_addr_q;
    assign m_data_o  = m_data_q;
    assign m_rd_o    = m_rd_q;
    assign m_wr_o    = m_wr_q;
    assign i_data_o  = i_data_q;
    assign d_data_o  = d_data_q;
    assign err_o     = err_q;
    assign i_ready_o = (state_q == ST_RESP) && (owner_q == OWN_I);
    assign d_ready_o = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (default build, fixed data priority).
// Fetch addresses live below 0x200, data addresses at 0x200 and above, so
// the memory responder can tell which port owns the access on the bus.
module tb_mem_port_arbiter;

    localparam int TO = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        i_rd_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic [31:0] i_data_o;
    logic        i_ready_o;
    logic        d_rd_i = 1'b0;
    logic        d_wr_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_data_i = '0;
    logic [31:0] d_data_o;
    logic        d_ready_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic        m_rd_o;
    logic        m_wr_o;
    logic [31:0] m_data_i = '0;
    logic        m_ready_i = 1'b0;
    logic        err_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_rd_i    (i_rd_i),
        .i_addr_i  (i_addr_i),
        .i_data_o  (i_data_o),
        .i_ready_o (i_ready_o),
        .d_rd_i    (d_rd_i),
        .d_wr_i    (d_wr_i),
        .d_addr_i  (d_addr_i),
        .d_data_i  (d_data_i),
        .d_data_o  (d_data_o),
        .d_ready_o (d_ready_o),
        .m_addr_o  (m_addr_o),
        .m_data_o  (m_data_o),
        .m_rd_o    (m_rd_o),
        .m_wr_o    (m_wr_o),
        .m_data_i  (m_data_i),
        .m_ready_i (m_ready_i),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_i_q[$];
    exp_t exp_d_q[$];
    int   pulse_i_q[$];
    int   pulse_d_q[$];
    int   lat_i = 0;
    int   lat_d = 0;
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] model_last_d = '0;
    logic [31:0] hold_i = '0;
    logic [31:0] hold_d = '0;
    int   last_i_cyc = 0;
    int   last_d_cyc = 0;

    always @(posedge clk_i) cyc++;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return r % 4;
        if (r <= 7) return 7;
        if (r == 8) return TO - 1;
        return TO + int'($urandom_range(0, 5));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m_rd"},    {31'b0, m_rd_o},    32'd0);
        chk({tag, "_m_wr"},    {31'b0, m_wr_o},    32'd0);
        chk({tag, "_m_addr"},  m_addr_o,           32'd0);
        chk({tag, "_m_data"},  m_data_o,           32'd0);
        chk({tag, "_i_ready"}, {31'b0, i_ready_o}, 32'd0);
        chk({tag, "_d_ready"}, {31'b0, d_ready_o}, 32'd0);
        chk({tag, "_i_data"},  i_data_o,           32'd0);
        chk({tag, "_d_data"},  d_data_o,           32'd0);
        chk({tag, "_err"},     {31'b0, err_o},     32'd0);
        chk({tag, "_busy"},    {31'b0, busy_o},    32'd0);
    endtask

    // Fetch request: push the expected reply, hold until ready, then drop.
    task automatic drive_i(input logic [31:0] a, input int lat);
        exp_t e;
        int   n;
        @(posedge clk_i); #1;
        lat_i    = lat;
        i_addr_i = a;
        i_rd_i   = 1'b1;
        e.err    = (lat >= TO);
        e.data   = e.err ? 32'd0 : ref_rd(a);
        exp_i_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!i_ready_o && n < 60);
        if (!i_ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL i_ready_wait: actual no pulse in %0d cycles required one pulse", n);
        end
        @(posedge clk_i); #1;
        i_rd_i = 1'b0;
    endtask

    // Load/store request; reference memory and last-data model update here.
    task automatic drive_d(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int lat);
        exp_t e;
        int   n;
        @(posedge clk_i); #1;
        lat_d    = lat;
        d_addr_i = a;
        d_data_i = wd;
        d_rd_i   = rd;
        d_wr_i   = wr;
        e.err    = (lat >= TO);
        if (e.err) begin
            e.data = 32'd0;
        end else if (wr) begin
            e.data     = model_last_d;
            ref_mem[a] = wd;
        end else begin
            e.data = ref_rd(a);
        end
        model_last_d = e.data;
        exp_d_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!d_ready_o && n < 60);
        if (!d_ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL d_ready_wait: actual no pulse in %0d cycles required one pulse", n);
        end
        @(posedge clk_i); #1;
        d_rd_i = 1'b0;
        d_wr_i = 1'b0;
    endtask

    // Memory responder: answers after the owner's chosen latency and checks
    // that the bus holds steady while the access is outstanding.
    initial begin
        logic        active;
        int          k;
        int          lat;
        int          s;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        srd;
        logic        swr;
        active = 1'b0;
        k = 0;
        lat = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                active    = 1'b0;
                m_ready_i = 1'b0;
                pulse_i_q.delete();
                pulse_d_q.delete();
                continue;
            end
            if (!active && (m_rd_o || m_wr_o)) begin
                active = 1'b1;
                k   = 0;
                s   = cyc;
                sa  = m_addr_o;
                sd  = m_data_o;
                srd = m_rd_o;
                swr = m_wr_o;
                if (sa >= 32'h200) begin
                    lat = lat_d;
                    pulse_d_q.push_back((lat < TO) ? s + lat + 1 : s + TO);
                end else begin
                    lat = lat_i;
                    pulse_i_q.push_back((lat < TO) ? s + lat + 1 : s + TO);
                end
            end
            if (active && (m_rd_o || m_wr_o)) begin
                chk("bus_addr_hold", m_addr_o, sa);
                chk("bus_data_hold", m_data_o, sd);
                chk("bus_rd_hold",   {31'b0, m_rd_o}, {31'b0, srd});
                chk("bus_wr_hold",   {31'b0, m_wr_o}, {31'b0, swr});
                chk("bus_busy",      {31'b0, busy_o}, 32'd1);
                if (k == lat) begin
                    m_ready_i = 1'b1;
                    m_data_i  = srd ? mem_rd(sa) : $urandom;
                    if (swr) mem[sa] = sd;
                end else begin
                    m_ready_i = 1'b0;
                    m_data_i  = $urandom;
                end
                k++;
            end else begin
                active    = 1'b0;
                m_ready_i = 1'b0;
                m_data_i  = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each ready pulse.
    initial begin
        exp_t e;
        int   p;
        forever begin
            @(negedge clk_i);
            if (rst_i) continue;
            if (i_ready_o || d_ready_o) begin
                chk("ready_exclusive", {31'b0, i_ready_o & d_ready_o}, 32'd0);
            end else begin
                chk("err_outside_pulse", {31'b0, err_o}, 32'd0);
            end
            if (i_ready_o) begin
                last_i_cyc = cyc;
                if (exp_i_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL i_pulse: actual unexpected pulse required none (cycle %0d)", cyc);
                end else begin
                    e = exp_i_q.pop_front();
                    chk("i_data", i_data_o, e.data);
                    chk("i_err", {31'b0, err_o}, {31'b0, e.err});
                    hold_i = e.data;
                end
                if (pulse_i_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL i_pulse_cycle: actual pulse with no bus access required none");
                end else begin
                    p = pulse_i_q.pop_front();
                    chk("i_pulse_cycle", cyc, p);
                end
            end else begin
                chk("i_data_hold", i_data_o, hold_i);
            end
            if (d_ready_o) begin
                last_d_cyc = cyc;
                if (exp_d_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL d_pulse: actual unexpected pulse required none (cycle %0d)", cyc);
                end else begin
                    e = exp_d_q.pop_front();
                    chk("d_data", d_data_o, e.data);
                    chk("d_err", {31'b0, err_o}, {31'b0, e.err});
                    hold_d = e.data;
                end
                if (pulse_d_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL d_pulse_cycle: actual pulse with no bus access required none");
                end else begin
                    p = pulse_d_q.pop_front();
                    chk("d_pulse_cycle", cyc, p);
                end
            end else begin
                chk("d_data_hold", d_data_o, hold_d);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: actual still running required finish");
        $fatal(1, "time limit");
    end

    initial begin
        mem[32'h100]     = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_idle_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_idle_outputs("post_reset");

        // Single fetch, memory ready in the first BUSY cycle
        fork
            drive_i(32'h100, 0);
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                @(negedge clk_i);
                chk("fetch_m_rd",   {31'b0, m_rd_o}, 32'd1);
                chk("fetch_m_wr",   {31'b0, m_wr_o}, 32'd0);
                chk("fetch_m_addr", m_addr_o, 32'h100);
                chk("fetch_busy",   {31'b0, busy_o}, 32'd1);
            end
        join

        // Simultaneous fetch and store: store first
        fork
            drive_i(32'h104, 0);
            drive_d(1'b0, 1'b1, 32'h200, 32'h12345678, 0);
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                @(negedge clk_i);
                chk("prio_m_wr",   {31'b0, m_wr_o}, 32'd1);
                chk("prio_m_rd",   {31'b0, m_rd_o}, 32'd0);
                chk("prio_m_addr", m_addr_o, 32'h200);
                chk("prio_m_data", m_data_o, 32'h12345678);
            end
        join
        chk("prio_d_before_i", {31'b0, (last_d_cyc < last_i_cyc) ? 1'b1 : 1'b0}, 32'd1);

        // Slow memory, then readback of the earlier store
        drive_d(1'b1, 1'b0, 32'h204, 32'd0, 7);
        drive_d(1'b1, 1'b0, 32'h200, 32'd0, 0);

        // Watchdog boundary: last cycle still succeeds, one more times out
        drive_d(1'b1, 1'b0, 32'h208, 32'd0, TO - 1);
        drive_d(1'b1, 1'b0, 32'h208, 32'd0, TO);
        drive_d(1'b1, 1'b0, 32'h208, 32'd0, 1);
        drive_i(32'h10C, TO + 3);
        drive_i(32'h10C, 2);

        // Read+write together is a write
        fork
            drive_d(1'b1, 1'b1, 32'h20C, 32'hCAFEF00D, 0);
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                @(negedge clk_i);
                chk("rw_m_wr", {31'b0, m_wr_o}, 32'd1);
                chk("rw_m_rd", {31'b0, m_rd_o}, 32'd0);
            end
        join
        drive_d(1'b1, 1'b0, 32'h20C, 32'd0, 0);

        // Reset in the middle of a load with a fetch pending
        @(posedge clk_i); #1;
        lat_d    = 30;
        d_addr_i = 32'h210;
        d_rd_i   = 1'b1;
        d_wr_i   = 1'b0;
        lat_i    = 0;
        i_addr_i = 32'h108;
        i_rd_i   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i  = 1'b1;
        d_rd_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk_idle_outputs("mid_reset");
        exp_i_q.delete();
        exp_d_q.delete();
        hold_i = '0;
        hold_d = '0;
        model_last_d = '0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive_i(32'h108, 0);

        // Randomized traffic on both ports at once
        fork
            for (int t = 0; t < 60; t++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk_i);
                drive_i(32'h100 + 4 * $urandom_range(0, 31), rand_lat());
            end
            for (int t = 0; t < 60; t++) begin
                int op;
                repeat ($urandom_range(0, 2)) @(posedge clk_i);
                op = int'($urandom_range(0, 9));
                drive_d((op < 5) || (op == 9), (op >= 5), 32'h200 + 4 * $urandom_range(0, 15),
                        $urandom, rand_lat());
            end
        join

        repeat (5) @(posedge clk_i);
        chk("exp_i_drained", exp_i_q.size(), 32'd0);
        chk("exp_d_drained", exp_d_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
